// File: rtl/ex_mem_pkg.sv
// Shared widths, control-bit positions and the default EX->MEM payload layout.
package ex_mem_pkg;

    localparam int DATA_WIDTH_D     = 64;
    localparam int REG_ID_WIDTH_D   = 5;
    localparam int MEM_CTRL_WIDTH_D = 2;
    localparam int WB_CTRL_WIDTH_D  = 2;

    localparam int MEM_RD     = 1;
    localparam int MEM_WR     = 0;
    localparam int WB_REGWR   = 1;
    localparam int WB_MEM2REG = 0;

    typedef struct packed {
        logic [DATA_WIDTH_D-1:0]     target;
        logic                        branch_taken;
        logic [DATA_WIDTH_D-1:0]     alu_res;
        logic [DATA_WIDTH_D-1:0]     write_data;
        logic [REG_ID_WIDTH_D-1:0]   dest;
        logic [MEM_CTRL_WIDTH_D-1:0] mem_ctrl;
        logic [WB_CTRL_WIDTH_D-1:0]  wb_ctrl;
    } ex_mem_payload_t;

    localparam int PAYLOAD_W_D = $bits(ex_mem_payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main slot M drives the output, skid slot S catches
// the entry accepted while M is stalled, so in_ready never depends on out_ready.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             in_xfer_s;
    logic             out_xfer_s;

    assign in_ready_o  = !s_valid_q && !reset;
    assign in_xfer_s   = in_valid_i && in_ready_o;
    assign out_xfer_s  = m_valid_q && out_ready_i;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;
    assign occupancy_o = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    // Slot next-state: S refills M first to keep FIFO order; flush drops valids but keeps payloads.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (!m_valid_q || out_xfer_s) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = in_xfer_s;
                if (in_xfer_s) begin
                    s_data_d = in_data_i;
                end else begin
                    s_data_d = s_data_q;
                end
            end else if (in_xfer_s) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data_i;
            end else begin
                m_valid_d = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data_i;
            end else begin
                s_valid_d = s_valid_q;
            end
        end
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_d;
        end
    end

    // Slot registers with synchronous reset that also clears payloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= {WIDTH{1'b0}};
            s_data_q  <= {WIDTH{1'b0}};
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

    pipe_skid_buf_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .m_valid_i (m_valid_q),
        .s_valid_i (s_valid_q)
    );

endmodule

// File: rtl/pipe_skid_buf_chk.sv
// Property checker for the skid buffer: the skid slot may only hold data while the main slot does.
module pipe_skid_buf_chk (
    input logic clk,
    input logic reset,
    input logic m_valid_i,
    input logic s_valid_i
);

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (reset) !(s_valid_i && !m_valid_i));

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM boundary register with handshake, skid buffer and flush; control groups masked on bubbles.
// Define EX_MEM_STALL_CNT_EN to build the saturating back-pressure cycle counter.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_D,
    parameter int REG_ID_WIDTH   = REG_ID_WIDTH_D,
    parameter int MEM_CTRL_WIDTH = MEM_CTRL_WIDTH_D,
    parameter int WB_CTRL_WIDTH  = WB_CTRL_WIDTH_D
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     target_in,
    input  logic                      branch_taken_in,
    input  logic [DATA_WIDTH-1:0]     alu_res_in,
    input  logic [DATA_WIDTH-1:0]     write_data_in,
    input  logic [REG_ID_WIDTH-1:0]   dest_in,
    input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_in,
    input  logic [WB_CTRL_WIDTH-1:0]  wb_ctrl_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     target_out,
    output logic                      branch_taken_out,
    output logic [DATA_WIDTH-1:0]     alu_res_out,
    output logic [DATA_WIDTH-1:0]     write_data_out,
    output logic [REG_ID_WIDTH-1:0]   dest_out,
    output logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_out,
    output logic [WB_CTRL_WIDTH-1:0]  wb_ctrl_out,
    output logic [1:0]                occupancy,
    output logic [31:0]               stall_cycles
);

    localparam int PAYLOAD_W = 3 * DATA_WIDTH + 1 + REG_ID_WIDTH + MEM_CTRL_WIDTH + WB_CTRL_WIDTH;

    logic [PAYLOAD_W-1:0]      in_payload_s;
    logic [PAYLOAD_W-1:0]      out_payload_s;
    logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_raw_s;
    logic [WB_CTRL_WIDTH-1:0]  wb_ctrl_raw_s;

    assign in_payload_s = {target_in, branch_taken_in, alu_res_in, write_data_in,
                           dest_in, mem_ctrl_in, wb_ctrl_in};

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_payload_s),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_payload_s),
        .occupancy_o (occupancy)
    );

    assign {target_out, branch_taken_out, alu_res_out, write_data_out,
            dest_out, mem_ctrl_raw_s, wb_ctrl_raw_s} = out_payload_s;

    // A bubble must never write memory or the register file.
    assign mem_ctrl_out = out_valid ? mem_ctrl_raw_s : {MEM_CTRL_WIDTH{1'b0}};
    assign wb_ctrl_out  = out_valid ? wb_ctrl_raw_s  : {WB_CTRL_WIDTH{1'b0}};

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count stalled-output cycles, saturating; flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: streaming, back-pressure, flush, reset, bubble masking, stall count.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] target_in, alu_res_in, write_data_in;
    logic [63:0] target_out, alu_res_out, write_data_out;
    logic        branch_taken_in, branch_taken_out;
    logic [4:0]  dest_in, dest_out;
    logic [1:0]  mem_ctrl_in, wb_ctrl_in, mem_ctrl_out, wb_ctrl_out, occupancy;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

`ifdef EX_MEM_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd10;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .target_in        (target_in),
        .branch_taken_in  (branch_taken_in),
        .alu_res_in       (alu_res_in),
        .write_data_in    (write_data_in),
        .dest_in          (dest_in),
        .mem_ctrl_in      (mem_ctrl_in),
        .wb_ctrl_in       (wb_ctrl_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .target_out       (target_out),
        .branch_taken_out (branch_taken_out),
        .alu_res_out      (alu_res_out),
        .write_data_out   (write_data_out),
        .dest_out         (dest_out),
        .mem_ctrl_out     (mem_ctrl_out),
        .wb_ctrl_out      (wb_ctrl_out),
        .occupancy        (occupancy),
        .stall_cycles     (stall_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] alu, input logic [4:0] dst,
                         input logic [1:0] mc, input logic [1:0] wc);
        in_valid        = 1'b1;
        alu_res_in      = alu;
        target_in       = alu + 64'h100;
        write_data_in   = alu + 64'h200;
        branch_taken_in = alu[0];
        dest_in         = dst;
        mem_ctrl_in     = mc;
        wb_ctrl_in      = wc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; target_in = 64'd0; alu_res_in = 64'd0; write_data_in = 64'd0;
        branch_taken_in = 1'b0; dest_in = 5'd0; mem_ctrl_in = 2'b00; wb_ctrl_in = 2'b00;
        step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_occ", {62'd0, occupancy}, 64'd0);
        chk("rst_alu", alu_res_out, 64'd0);
        chk("rst_stall", {32'd0, stall_cycles}, 64'd0);

        // Bubble masking: control inputs present but no valid entry.
        reset = 1'b0; mem_ctrl_in = 2'b01; wb_ctrl_in = 2'b10;
        step();
        chk("bub_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bub_mem_ctrl", {62'd0, mem_ctrl_out}, 64'd0);
        chk("bub_wb_ctrl", {62'd0, wb_ctrl_out}, 64'd0);
        chk("bub_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(64'(i), 5'(i), 2'b10, 2'b11);
            step();
            chk("str_alu", alu_res_out, 64'(i));
            chk("str_target", target_out, 64'(i) + 64'h100);
            chk("str_occ", {62'd0, occupancy}, 64'd1);
            chk("str_in_ready", {63'd0, in_ready}, 64'd1);
            chk("str_mem_ctrl", {62'd0, mem_ctrl_out}, 64'd2);
        end
        in_valid = 1'b0;
        step();
        chk("str_drain_valid", {63'd0, out_valid}, 64'd0);
        chk("str_drain_occ", {62'd0, occupancy}, 64'd0);

        // Back-pressure: A then B held, then released in order.
        out_ready = 1'b0;
        drive(64'hA, 5'd3, 2'b10, 2'b10);
        step();
        chk("bp_occ1", {62'd0, occupancy}, 64'd1);
        chk("bp_dest_a", {59'd0, dest_out}, 64'd3);
        drive(64'hB, 5'd7, 2'b01, 2'b11);
        step();
        chk("bp_occ2", {62'd0, occupancy}, 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_a", {59'd0, dest_out}, 64'd3);
        chk("bp_hold_wb", {62'd0, wb_ctrl_out}, 64'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_dest_b", {59'd0, dest_out}, 64'd7);
        chk("bp_alu_b", alu_res_out, 64'hB);
        chk("bp_occ_b", {62'd0, occupancy}, 64'd1);
        step();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush with both slots full and a simultaneous input.
        out_ready = 1'b0;
        drive(64'h11, 5'd1, 2'b01, 2'b10);
        step();
        drive(64'h22, 5'd2, 2'b01, 2'b10);
        step();
        chk("fl_occ_pre", {62'd0, occupancy}, 64'd2);
        drive(64'h33, 5'd4, 2'b01, 2'b10);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_occ", {62'd0, occupancy}, 64'd0);
        chk("fl_mem_ctrl", {62'd0, mem_ctrl_out}, 64'd0);
        chk("fl_wb_ctrl", {62'd0, wb_ctrl_out}, 64'd0);
        chk("fl_payload_kept", alu_res_out, 64'h11);
        step();
        chk("fl_stays_empty", {62'd0, occupancy}, 64'd0);

        // Reset mid-operation.
        drive(64'h44, 5'd5, 2'b10, 2'b11);
        step();
        drive(64'h55, 5'd6, 2'b10, 2'b11);
        step();
        chk("rm_occ_pre", {62'd0, occupancy}, 64'd2);
        in_valid = 1'b0; reset = 1'b1;
        step();
        chk("rm_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rm_alu", alu_res_out, 64'd0);
        chk("rm_target", target_out, 64'd0);
        chk("rm_wdata", write_data_out, 64'd0);
        chk("rm_dest", {59'd0, dest_out}, 64'd0);
        chk("rm_branch", {63'd0, branch_taken_out}, 64'd0);
        chk("rm_occ", {62'd0, occupancy}, 64'd0);
        chk("rm_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        step();
        chk("rm_in_ready_after", {63'd0, in_ready}, 64'd1);

        // Stall counting: 10 stalled cycles, then a flush cycle with no stall, then reset.
        drive(64'h66, 5'd8, 2'b10, 2'b10);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("st_count", {32'd0, stall_cycles}, {32'd0, STALL_EXP});
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("st_after_flush", {32'd0, stall_cycles}, {32'd0, STALL_EXP});
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("st_after_reset", {32'd0, stall_cycles}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX->MEM pipeline boundary register with valid/ready handshaking, a 2-entry skid buffer and a flush input.
- Replaces the free-running EX/MEM register, so EX can be back-pressured by MEM (e.g. a D-cache miss) and squashed on a mispredict or trap.
- Carries the branch target, branch decision, ALU result, store data, destination register ID, and the MEM and WB control groups.

Parameters:
- DATA_WIDTH, 64, width of target, ALU result and store data.
- REG_ID_WIDTH, 5, destination register ID width.
- MEM_CTRL_WIDTH, 2, MEM control group width ([1]=mem_read, [0]=mem_write).
- WB_CTRL_WIDTH, 2, WB control group width ([1]=reg_write, [0]=mem_to_reg).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash all held and incoming entries
- in_valid  in  1  EX presents a valid entry
- in_ready  out  1  block can accept an entry
- target_in  in  DATA_WIDTH  branch target
- branch_taken_in  in  1  branch decision
- alu_res_in  in  DATA_WIDTH  ALU result
- write_data_in  in  DATA_WIDTH  store data
- dest_in  in  REG_ID_WIDTH  destination register ID
- mem_ctrl_in  in  MEM_CTRL_WIDTH  MEM control group
- wb_ctrl_in  in  WB_CTRL_WIDTH  WB control group
- out_valid  out  1  entry presented to MEM
- out_ready  in  1  MEM accepts the entry
- target_out, branch_taken_out, alu_res_out, write_data_out, dest_out, mem_ctrl_out, wb_ctrl_out  out  (widths as inputs)  held entry
- occupancy  out  2  number of entries held (0..2)
- stall_cycles  out  32  back-pressure cycle count (see Optional Feature)

Behaviour:
- Clocking: clk; reset is reset, synchronous, active-high.
- Storage: main slot M (drives outputs) and skid slot S; each has a valid bit plus payload.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !S.valid && !reset. It depends only on registered state, with no combinational path from out_ready.
  - out_valid = M.valid.
- Latency: an accepted entry appears at the outputs on the next cycle. Throughput is 1 entry/cycle when out_ready is held high.
- Next-state rules, when flush=0 and reset=0:
  - M empty or out transfer: M <- S if S.valid (S emptied, and a simultaneous input goes to S); otherwise M <- input if an input transfer occurs; otherwise M.valid <- 0.
  - M full and no out transfer: an input transfer goes to S.
- Ordering: strict FIFO order. An entry in S always leaves before any newer entry.
- Flush:
  - Both valid bits clear next cycle.
  - An input accepted in the flush cycle is discarded.
  - An out transfer in the flush cycle still completes.
  - Payload registers are not cleared.
- Reset:
  - Both valid bits are 0 and all payload registers are 0.
  - Every output is therefore 0, except stall_cycles (0), and in_ready is 0 while reset is high.
  - Reset mid-operation drops all entries.
- Control qualification: mem_ctrl_out and wb_ctrl_out are forced to 0 whenever out_valid=0, so a bubble can never write memory or the register file. Data outputs are not masked.
- occupancy = M.valid + S.valid. The state S.valid && !M.valid is illegal; an assertion checks it.
- Simultaneous reset and flush: reset wins; the result is identical.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined: stall_cycles increments every cycle with out_valid && !out_ready.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared by reset only, not by flush.
- Undefined: no counter flops exist; stall_cycles is tied to 0.

Decomposition:
- Package ex_mem_pkg holds:
  - default width constants (DATA_WIDTH_D=64, REG_ID_WIDTH_D=5);
  - control bit-index constants (MEM_RD=1, MEM_WR=0, WB_REGWR=1, WB_MEM2REG=0);
  - a packed struct typedef ex_mem_payload_t built from the defaults.
- The module computes localparam PAYLOAD_W as the sum of all field widths.
- One sub-module, pipe_skid_buf:
  - generic over a WIDTH parameter;
  - owns M/S, valid bits, handshake and flush;
  - the top level packs and unpacks fields, masks the control groups, and holds the counter.

Test Plan:
1. Streaming: out_ready=1; drive 4 entries with alu_res_in=1..4 on consecutive cycles -> alu_res_out=1..4 on cycles 1..4; occupancy never exceeds 1; in_ready stays 1.
2. Back-pressure: out_ready=0; drive entries A (dest 3) and B (dest 7) -> occupancy=2 and in_ready=0 after the 2nd edge. Then out_ready=1 -> A is presented, then B, with no loss or duplication.
3. Flush with S full: occupancy=2, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, occupancy=0, mem_ctrl_out=0, wb_ctrl_out=0.
4. Reset mid-operation: occupancy=2, assert reset -> next cycle out_valid=0, all payload outputs 0, occupancy=0; in_ready=0 during reset and 1 in the first cycle after it.
5. Bubble masking: in_valid=0 with mem_ctrl_in=2'b01 and wb_ctrl_in=2'b10 -> mem_ctrl_out=0 and wb_ctrl_out=0 while out_valid=0.
6. EX_MEM_STALL_CNT_EN defined: hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cycles=10; then flush -> stays 10; then reset -> 0.
